// File: rtl/elevator_pkg.sv
// Shared encodings and request-scan helpers for the elevator controller.
package elevator_pkg;

  localparam int unsigned MAX_FLOORS = 32;
  localparam int unsigned FIDX_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DOOR_OPEN = 3'd1,
    ST_MOVE_UP   = 3'd2,
    ST_MOVE_DOWN = 3'd3,
    ST_EMERGENCY = 3'd4
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Any pending call strictly above the given floor.
  function automatic logic req_above(input logic [MAX_FLOORS-1:0] req,
                                     input logic [FIDX_W-1:0] floor);
    return |((req >> floor) >> 1);
  endfunction

  // Any pending call strictly below the given floor.
  function automatic logic req_below(input logic [MAX_FLOORS-1:0] req,
                                     input logic [FIDX_W-1:0] floor);
    return |(req & ((MAX_FLOORS'(1) << floor) - MAX_FLOORS'(1)));
  endfunction

endpackage

// File: rtl/tick_generator.sv
// Free-running divider producing a one-cycle enable every CLK_FREQ_HZ clocks.
module tick_generator #(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] cnt;

  // Count to CNT_MAX, wrap, and flag the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_MAX);
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// N-floor elevator controller: SCAN scheduling, tick-timed travel/door, SOS and overweight.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = 3,
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned TRAVEL_TICKS = 2,
  parameter int unsigned DOOR_TICKS   = 3
) (
  input  logic                  CLK_50,
  input  logic                  RST_N,
  input  logic [NUM_FLOORS-1:0] floor_button,
  input  logic                  sos_button,
  input  logic                  weight_sensor,
  output logic [NUM_FLOORS-1:0] floor_led,
  output logic [NUM_FLOORS-1:0] request_led,
  output logic                  sos_led,
  output logic                  emergency_led,
  output logic                  weight_led,
  output logic                  door_status_led,
  output logic                  moving_up,
  output logic                  moving_down
);

  localparam int unsigned FLOOR_W  = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int unsigned TRAVEL_W = $clog2(TRAVEL_TICKS + 1);
  localparam int unsigned DOOR_W   = $clog2(DOOR_TICKS + 1);

  logic                  tick;
  logic [NUM_FLOORS-1:0] btn_s1, btn_s2, btn_d, call;
  logic                  sos_s1, sos_s2, sos_d, sos_pulse;
  logic                  wt_s1, wt_s2;

  state_t                state, state_nx;
  dir_t                  dir, dir_nx;
  logic [FLOOR_W-1:0]    floor, floor_nx, floor_step;
  logic [NUM_FLOORS-1:0] req, req_nx;
  logic [TRAVEL_W-1:0]   travel_cnt, travel_cnt_nx;
  logic [DOOR_W-1:0]     door_cnt, door_cnt_nx;
  logic                  above, below, step_ahead, at_limit;

  tick_generator #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk   (CLK_50),
    .rst_n (RST_N),
    .tick  (tick)
  );

  // Two-flop synchronisers plus edge-history flops for the raw buttons.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      btn_s1 <= '0; btn_s2 <= '0; btn_d <= '0;
      sos_s1 <= 1'b0; sos_s2 <= 1'b0; sos_d <= 1'b0;
      wt_s1  <= 1'b0; wt_s2  <= 1'b0;
    end else begin
      btn_s1 <= floor_button; btn_s2 <= btn_s1; btn_d <= btn_s2;
      sos_s1 <= sos_button;   sos_s2 <= sos_s1; sos_d <= sos_s2;
      wt_s1  <= weight_sensor; wt_s2 <= wt_s1;
    end
  end

  assign call      = btn_s2 & ~btn_d;
  assign sos_pulse = sos_s2 & ~sos_d;
  assign above     = req_above(MAX_FLOORS'(req), FIDX_W'(floor));
  assign below     = req_below(MAX_FLOORS'(req), FIDX_W'(floor));

  // State register.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state, scheduling and call latching.
  always_comb begin
    state_nx      = state;
    dir_nx        = dir;
    floor_nx      = floor;
    req_nx        = req;
    travel_cnt_nx = travel_cnt;
    door_cnt_nx   = door_cnt;
    floor_step    = (state == ST_MOVE_DOWN) ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);
    step_ahead    = (state == ST_MOVE_DOWN) ? req_below(MAX_FLOORS'(req), FIDX_W'(floor_step))
                                            : req_above(MAX_FLOORS'(req), FIDX_W'(floor_step));
    at_limit      = ((state == ST_MOVE_UP) && (floor == FLOOR_W'(NUM_FLOORS - 1))) ||
                    ((state == ST_MOVE_DOWN) && (floor == '0));

    if (sos_pulse && (state != ST_EMERGENCY)) begin
      state_nx    = ST_EMERGENCY;
      req_nx      = '0;
      door_cnt_nx = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req[floor]) begin
            req_nx[floor] = 1'b0;
            state_nx      = ST_DOOR_OPEN;
            door_cnt_nx   = '0;
          end else if ((|req) && !wt_s2) begin
            travel_cnt_nx = '0;
            if (above) begin
              state_nx = ST_MOVE_UP;
              dir_nx   = DIR_UP;
            end else begin
              state_nx = ST_MOVE_DOWN;
              dir_nx   = DIR_DOWN;
            end
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (at_limit) begin
            state_nx      = ST_IDLE;
            travel_cnt_nx = '0;
          end else if (tick) begin
            if (travel_cnt == TRAVEL_W'(TRAVEL_TICKS - 1)) begin
              floor_nx      = floor_step;
              travel_cnt_nx = '0;
              if (req[floor_step]) begin
                req_nx[floor_step] = 1'b0;
                state_nx           = ST_DOOR_OPEN;
                door_cnt_nx        = '0;
              end else if (!step_ahead) begin
                state_nx = ST_IDLE;
              end
            end else begin
              travel_cnt_nx = travel_cnt + TRAVEL_W'(1);
            end
          end
        end
        ST_DOOR_OPEN: begin
          if (wt_s2) begin
            door_cnt_nx = '0;
          end else if (tick) begin
            if (door_cnt == DOOR_W'(DOOR_TICKS - 1)) begin
              door_cnt_nx = '0;
              if ((dir == DIR_UP) ? above : below) begin
                state_nx = (dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
              end else if ((dir == DIR_UP) ? below : above) begin
                state_nx = (dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                dir_nx   = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
              end else begin
                state_nx = ST_IDLE;
              end
            end else begin
              door_cnt_nx = door_cnt + DOOR_W'(1);
            end
          end
        end
        ST_EMERGENCY: begin
          if (sos_pulse) begin
            if (travel_cnt != '0) state_nx = (dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
            else                  state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase

      // A call at the parked floor re-opens the door instead of latching.
      if (state != ST_EMERGENCY) begin
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
          if (call[f]) begin
            if ((floor == FLOOR_W'(f)) && ((state == ST_IDLE) || (state == ST_DOOR_OPEN))) begin
              state_nx    = ST_DOOR_OPEN;
              dir_nx      = dir;
              door_cnt_nx = '0;
            end else begin
              req_nx[f] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Datapath registers and registered LED outputs.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      dir             <= DIR_UP;
      floor           <= '0;
      req             <= '0;
      travel_cnt      <= '0;
      door_cnt        <= '0;
      floor_led       <= NUM_FLOORS'(1);
      request_led     <= '0;
      sos_led         <= 1'b0;
      emergency_led   <= 1'b0;
      weight_led      <= 1'b0;
      door_status_led <= 1'b0;
      moving_up       <= 1'b0;
      moving_down     <= 1'b0;
    end else begin
      dir             <= dir_nx;
      floor           <= floor_nx;
      req             <= req_nx;
      travel_cnt      <= travel_cnt_nx;
      door_cnt        <= door_cnt_nx;
      floor_led       <= NUM_FLOORS'(1) << floor_nx;
      request_led     <= req_nx;
      sos_led         <= (state_nx == ST_EMERGENCY);
      emergency_led   <= (state_nx == ST_EMERGENCY) && (emergency_led ^ tick);
      weight_led      <= wt_s2;
      door_status_led <= (state_nx == ST_DOOR_OPEN) ||
                         ((state_nx == ST_EMERGENCY) && (travel_cnt_nx == '0));
      moving_up       <= (state_nx == ST_MOVE_UP);
      moving_down     <= (state_nx == ST_MOVE_DOWN);
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller with 4 floors and a 10-cycle tick.
module tb_elevator_controller;

  localparam int unsigned NF = 4;
  localparam int SEL_FLOOR = 0;
  localparam int SEL_DOOR  = 1;
  localparam int SEL_UP    = 2;
  localparam int SEL_DOWN  = 3;

  logic          CLK_50 = 1'b0;
  logic          RST_N  = 1'b1;
  logic [NF-1:0] floor_button = '0;
  logic          sos_button = 1'b0;
  logic          weight_sensor = 1'b0;
  logic [NF-1:0] floor_led, request_led;
  logic          sos_led, emergency_led, weight_led, door_status_led, moving_up, moving_down;

  int checks = 0;
  int errors = 0;

  always #5 CLK_50 = ~CLK_50;

  elevator_controller #(
    .NUM_FLOORS(NF), .CLK_FREQ_HZ(10), .TRAVEL_TICKS(2), .DOOR_TICKS(3)
  ) dut (
    .CLK_50(CLK_50), .RST_N(RST_N), .floor_button(floor_button),
    .sos_button(sos_button), .weight_sensor(weight_sensor),
    .floor_led(floor_led), .request_led(request_led), .sos_led(sos_led),
    .emergency_led(emergency_led), .weight_led(weight_led),
    .door_status_led(door_status_led), .moving_up(moving_up), .moving_down(moving_down)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  function automatic logic [3:0] sample(input int sel);
    case (sel)
      SEL_FLOOR: return floor_led;
      SEL_DOOR:  return {3'b000, door_status_led};
      SEL_UP:    return {3'b000, moving_up};
      SEL_DOWN:  return {3'b000, moving_down};
      default:   return 4'hx;
    endcase
  endfunction

  // Waits up to budget negedges for a signal to reach val; n = -1 on timeout.
  task automatic wait_sig(input int sel, input logic [3:0] val, input int budget, output int n);
    n = 0;
    while (sample(sel) !== val && n < budget) begin
      @(negedge CLK_50);
      n++;
    end
    if (sample(sel) !== val) n = -1;
  endtask

  task automatic test_reset();
    @(negedge CLK_50);
    RST_N = 1'b0;
    cycles(3);
    checks++; if (floor_led !== 4'b0001) begin errors++; $display("FAIL reset_floor_led got %b exp 0001", floor_led); end
    checks++; if (request_led !== 4'b0000) begin errors++; $display("FAIL reset_request_led got %b exp 0000", request_led); end
    checks++; if ({sos_led, emergency_led, weight_led, door_status_led, moving_up, moving_down} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got %b exp 000000", {sos_led, emergency_led, weight_led, door_status_led, moving_up, moving_down}); end
    RST_N = 1'b1;
    cycles(50);
    checks++; if (floor_led !== 4'b0001) begin errors++; $display("FAIL idle_floor_led got %b exp 0001", floor_led); end
    checks++; if (request_led !== 4'b0000) begin errors++; $display("FAIL idle_request_led got %b exp 0000", request_led); end
    checks++; if ({door_status_led, moving_up, moving_down} !== 3'b000)
      begin errors++; $display("FAIL idle_flags got %b exp 000", {door_status_led, moving_up, moving_down}); end
  endtask

  task automatic test_call_floor2();
    int n;
    floor_button[2] = 1'b1;
    cycles(2);
    checks++; if (request_led !== 4'b0000) begin errors++; $display("FAIL call_early got %b exp 0000", request_led); end
    cycles(1);
    checks++; if (request_led !== 4'b0100) begin errors++; $display("FAIL call_latency got %b exp 0100", request_led); end
    cycles(1);
    checks++; if (moving_up !== 1'b1) begin errors++; $display("FAIL call_depart got %b exp 1", moving_up); end
    floor_button[2] = 1'b0;
    wait_sig(SEL_FLOOR, 4'b0010, 40, n);
    checks++; if (n < 11 || n > 20) begin errors++; $display("FAIL call_first_floor cycles %0d exp 11..20", n); end
    checks++; if (moving_up !== 1'b1) begin errors++; $display("FAIL call_pass_floor1 got %b exp 1", moving_up); end
    wait_sig(SEL_FLOOR, 4'b0100, 40, n);
    checks++; if (n != 20) begin errors++; $display("FAIL call_floor_time cycles %0d exp 20", n); end
    checks++; if ({door_status_led, moving_up, request_led} !== 6'b100000)
      begin errors++; $display("FAIL call_arrive got %b exp 100000", {door_status_led, moving_up, request_led}); end
    wait_sig(SEL_DOOR, 4'b0000, 40, n);
    checks++; if (n != 30) begin errors++; $display("FAIL call_door_time cycles %0d exp 30", n); end
    checks++; if ({moving_up, moving_down, floor_led} !== 6'b000100)
      begin errors++; $display("FAIL call_idle got %b exp 000100", {moving_up, moving_down, floor_led}); end
  endtask

  task automatic test_scan();
    int n;
    RST_N = 1'b0;
    cycles(1);
    RST_N = 1'b1;
    cycles(2);
    floor_button[3] = 1'b1;
    cycles(4);
    floor_button[3] = 1'b0;
    wait_sig(SEL_FLOOR, 4'b0010, 40, n);
    checks++; if (n < 0 || moving_up !== 1'b1) begin errors++; $display("FAIL scan_floor1 cycles %0d up %b exp up 1", n, moving_up); end
    floor_button[0] = 1'b1;
    cycles(4);
    floor_button[0] = 1'b0;
    checks++; if ({request_led, moving_up} !== 5'b10011)
      begin errors++; $display("FAIL scan_pending got %b exp 10011", {request_led, moving_up}); end
    wait_sig(SEL_FLOOR, 4'b0100, 30, n);
    checks++; if (n != 16 || moving_up !== 1'b1) begin errors++; $display("FAIL scan_floor2 cycles %0d up %b exp 16 1", n, moving_up); end
    wait_sig(SEL_FLOOR, 4'b1000, 30, n);
    checks++; if (n != 20) begin errors++; $display("FAIL scan_floor3_time cycles %0d exp 20", n); end
    checks++; if ({door_status_led, request_led} !== 5'b10001)
      begin errors++; $display("FAIL scan_floor3 got %b exp 10001", {door_status_led, request_led}); end
    wait_sig(SEL_DOWN, 4'b0001, 40, n);
    checks++; if (n != 30) begin errors++; $display("FAIL scan_reverse cycles %0d exp 30", n); end
    wait_sig(SEL_FLOOR, 4'b0001, 80, n);
    checks++; if (n != 60) begin errors++; $display("FAIL scan_floor0_time cycles %0d exp 60", n); end
    checks++; if ({door_status_led, request_led} !== 5'b10000)
      begin errors++; $display("FAIL scan_floor0 got %b exp 10000", {door_status_led, request_led}); end
    wait_sig(SEL_DOOR, 4'b0000, 40, n);
    checks++; if (n != 30) begin errors++; $display("FAIL scan_close cycles %0d exp 30", n); end
  endtask

  task automatic test_weight();
    int n;
    floor_button[0] = 1'b1;
    cycles(3);
    checks++; if ({door_status_led, request_led} !== 5'b10000)
      begin errors++; $display("FAIL here_call got %b exp 10000", {door_status_led, request_led}); end
    cycles(1);
    floor_button[0] = 1'b0;
    floor_button[2] = 1'b1;
    cycles(4);
    floor_button[2] = 1'b0;
    checks++; if ({door_status_led, request_led} !== 5'b10100)
      begin errors++; $display("FAIL weight_setup got %b exp 10100", {door_status_led, request_led}); end
    weight_sensor = 1'b1;
    cycles(50);
    checks++; if ({door_status_led, moving_up, weight_led} !== 3'b101)
      begin errors++; $display("FAIL weight_hold got %b exp 101", {door_status_led, moving_up, weight_led}); end
    weight_sensor = 1'b0;
    wait_sig(SEL_UP, 4'b0001, 40, n);
    checks++; if (n < 23 || n > 32) begin errors++; $display("FAIL weight_release cycles %0d exp 23..32", n); end
    checks++; if (weight_led !== 1'b0) begin errors++; $display("FAIL weight_led_off got %b exp 0", weight_led); end
    wait_sig(SEL_FLOOR, 4'b0100, 50, n);
    checks++; if (n != 40 || door_status_led !== 1'b1) begin errors++; $display("FAIL weight_trip cycles %0d door %b exp 40 1", n, door_status_led); end
    wait_sig(SEL_DOOR, 4'b0000, 40, n);
    checks++; if (n != 30) begin errors++; $display("FAIL weight_close cycles %0d exp 30", n); end
  endtask

  task automatic test_sos();
    int n;
    int tog;
    logic prev;
    floor_button[0] = 1'b1;
    cycles(4);
    floor_button[0] = 1'b0;
    wait_sig(SEL_FLOOR, 4'b0010, 60, n);
    checks++; if (n < 0 || moving_down !== 1'b1) begin errors++; $display("FAIL sos_setup cycles %0d down %b exp down 1", n, moving_down); end
    cycles(15);
    sos_button = 1'b1;
    cycles(3);
    checks++; if ({sos_led, moving_down, door_status_led, request_led, floor_led} !== 11'b100_0000_0010)
      begin errors++; $display("FAIL sos_enter got %b exp 10000000010", {sos_led, moving_down, door_status_led, request_led, floor_led}); end
    sos_button = 1'b0;
    tog = 0;
    prev = emergency_led;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK_50);
      if (emergency_led !== prev) tog++;
      prev = emergency_led;
    end
    checks++; if (tog != 4) begin errors++; $display("FAIL sos_blink toggles %0d exp 4", tog); end
    floor_button[3] = 1'b1;
    cycles(4);
    floor_button[3] = 1'b0;
    checks++; if ({sos_led, request_led} !== 5'b10000)
      begin errors++; $display("FAIL sos_ignore_call got %b exp 10000", {sos_led, request_led}); end
    sos_button = 1'b1;
    cycles(3);
    checks++; if ({moving_down, sos_led, emergency_led} !== 3'b100)
      begin errors++; $display("FAIL sos_exit got %b exp 100", {moving_down, sos_led, emergency_led}); end
    sos_button = 1'b0;
    wait_sig(SEL_FLOOR, 4'b0001, 15, n);
    checks++; if (n < 1 || n > 10) begin errors++; $display("FAIL sos_finish cycles %0d exp 1..10", n); end
    checks++; if ({door_status_led, moving_down, moving_up} !== 3'b000)
      begin errors++; $display("FAIL sos_idle got %b exp 000", {door_status_led, moving_down, moving_up}); end
  endtask

  task automatic test_sos_vs_call();
    floor_button[3] = 1'b1;
    sos_button = 1'b1;
    cycles(3);
    checks++; if ({sos_led, door_status_led, request_led} !== 6'b110000)
      begin errors++; $display("FAIL simul_enter got %b exp 110000", {sos_led, door_status_led, request_led}); end
    cycles(1);
    floor_button[3] = 1'b0;
    sos_button = 1'b0;
    cycles(2);
    sos_button = 1'b1;
    cycles(3);
    checks++; if ({sos_led, door_status_led, moving_up, request_led} !== 7'b0000000)
      begin errors++; $display("FAIL simul_exit got %b exp 0000000", {sos_led, door_status_led, moving_up, request_led}); end
    sos_button = 1'b0;
    cycles(2);
  endtask

  task automatic test_reset_mid_move();
    int n;
    floor_button[3] = 1'b1;
    cycles(4);
    floor_button[3] = 1'b0;
    wait_sig(SEL_FLOOR, 4'b0010, 40, n);
    cycles(5);
    RST_N = 1'b0;
    #1;
    checks++; if ({floor_led, request_led, moving_up, door_status_led} !== 10'b0001_0000_00)
      begin errors++; $display("FAIL rst_async got %b exp 0001000000", {floor_led, request_led, moving_up, door_status_led}); end
    @(negedge CLK_50);
    RST_N = 1'b1;
    cycles(30);
    checks++; if ({floor_led, request_led, moving_up, moving_down} !== 10'b0001_0000_00)
      begin errors++; $display("FAIL rst_no_homing got %b exp 0001000000", {floor_led, request_led, moving_up, moving_down}); end
  endtask

  initial begin
    test_reset();
    test_call_floor2();
    test_scan();
    test_weight();
    test_sos();
    test_sos_vs_call();
    test_reset_mid_move();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
